sensor_conditioner: RTL and testbench
=====================================

Name: sensor_conditioner

Overview:
- Upstream stage of the home-automation controller.
- Turns raw sensor inputs into the four clean condition bits the combinational controller consumes: pir, isDark, tempHigh, authorized.
- Conditioning applied: PIR debounce plus motion hold-stretch, hysteresis comparators on the 8-bit light and temperature samples, and a badge authentication session FSM with timeout and lockout.
- All outputs are registered and connect directly to the controller inputs of the same names.

Parameters:
DEB_TICKS, 4, consecutive ticks pir_raw must differ from the debounced state before the change is accepted (≥1)
PIR_HOLD, 8, ticks pir stays high after debounced motion falls (0 = no stretch)
DARK_ON, 8'd60, light_lvl strictly below this sets isDark
DARK_OFF, 8'd80, light_lvl strictly above this clears isDark (DARK_ON ≤ DARK_OFF)
TEMP_ON, 8'd30, temp_lvl ≥ this sets tempHigh
TEMP_OFF, 8'd27, temp_lvl ≤ this clears tempHigh (TEMP_OFF < TEMP_ON)
AUTH_HOLD, 16, ticks an authorized session lasts (1..65535)
MAX_FAILS, 3, consecutive badge failures that trigger lockout (1..15)
LOCK_TICKS, 32, lockout duration in ticks (1..65535)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tick  input  1  one-cycle sample/time-base enable
pir_raw  input  1  raw PIR detector, asynchronous to clk but assumed pre-synchronised
light_lvl  input  8  ambient light sample
temp_lvl  input  8  temperature sample
badge_ok  input  1  one-cycle pulse: valid badge presented
badge_fail  input  1  one-cycle pulse: invalid badge presented
logout  input  1  one-cycle pulse: end session
pir  output  1  conditioned motion
isDark  output  1  dark condition with hysteresis
tempHigh  output  1  over-temperature with hysteresis
authorized  output  1  authenticated session active

Behaviour:
Reset:
- rst=1 at a clk edge clears all outputs, the debounced state, all counters and timers, and fail_cnt to 0.
- Auth FSM returns to IDLE.
- rst overrides every other input, including mid-session and mid-lockout.

Timing base:
- Debounce, hold, comparators and timers advance only on cycles with tick=1.
- badge_ok, badge_fail and logout are sampled every cycle.

Debounce:
- deb and cnt are updated on tick only.
- If pir_raw == deb: cnt ← 0.
- Else if cnt+1 == DEB_TICKS: deb ← pir_raw, cnt ← 0.
- Else: cnt ← cnt+1.
- Any tick where raw equals deb restarts the count.

Hold-stretch:
- If deb=1: hold ← PIR_HOLD, pir ← 1.
- Else, on tick with hold≠0: hold ← hold−1.
- pir ← deb | (hold≠0).
- After deb falls, pir stays high for exactly PIR_HOLD ticks.

isDark (updated on tick):
- light_lvl < DARK_ON → 1.
- Else light_lvl > DARK_OFF → 0.
- Else hold.

tempHigh (updated on tick):
- temp_lvl ≥ TEMP_ON → 1.
- Else temp_lvl ≤ TEMP_OFF → 0.
- Else hold.

Auth FSM: states IDLE, AUTH, LOCKOUT; 16-bit timer; 4-bit fail_cnt; authorized = (state==AUTH), decoded from the state register.
- IDLE, badge_fail → fail_cnt+1. Reaching MAX_FAILS → LOCKOUT, timer ← LOCK_TICKS, fail_cnt ← 0.
- IDLE, badge_ok (no fail that cycle) → AUTH, timer ← AUTH_HOLD, fail_cnt ← 0.
- AUTH, logout → IDLE.
- AUTH, badge_ok → timer reload to AUTH_HOLD.
- AUTH, tick with timer==1 → IDLE.
- AUTH, tick otherwise → timer−1.
- AUTH, badge_fail → ignored.
- LOCKOUT: badge_ok, badge_fail and logout all ignored. Tick with timer==1 → IDLE; otherwise tick → timer−1.

Simultaneous events:
- badge_ok with badge_fail: treated as a failure only.
- logout with badge_ok in AUTH: logout wins.
- Reload (badge_ok) with the expiring tick: reload wins.
- logout in IDLE: no effect.

Latency:
- Every output changes on the clk edge that samples the causing input or tick.
- No combinational path from any input to any output.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs → all four outputs 0, FSM IDLE.
- Debounce/hold: pir_raw=1 for 3 ticks then 0 → pir stays 0. pir_raw=1 held → pir rises on the 4th tick edge. pir_raw=0 held → pir stays 1 for 4 ticks (debounce) + 8 ticks (hold), then 0.
- Hysteresis, light: light_lvl 100→70→59→70→80→81 → isDark 0,0,1,1,1,0.
- Hysteresis, temp: temp_lvl 25→29→30→28→27 → tempHigh 0,0,1,1,0.
- Auth session: badge_ok → authorized=1 the next cycle, drops after exactly 16 ticks. Reload at tick 10 → session extends to 26 ticks. logout mid-session → 0 the next cycle.
- Lockout: 3 badge_fail pulses, then badge_ok during the next 32 ticks → authorized stays 0. After 32 ticks, badge_ok → authorized=1. Separately: badge_ok+badge_fail in the same cycle → authorized stays 0 and fail_cnt increments.

Source files
------------

// File: rtl/sensor_conditioner.sv
// Conditions raw home-automation sensor inputs into four registered controller bits:
// debounced/stretched motion, dark and over-temperature hysteresis, and badge session state.
module sensor_conditioner #(
  parameter int unsigned DEB_TICKS  = 4,
  parameter int unsigned PIR_HOLD   = 8,
  parameter logic [7:0]  DARK_ON    = 8'd60,
  parameter logic [7:0]  DARK_OFF   = 8'd80,
  parameter logic [7:0]  TEMP_ON    = 8'd30,
  parameter logic [7:0]  TEMP_OFF   = 8'd27,
  parameter int unsigned AUTH_HOLD  = 16,
  parameter int unsigned MAX_FAILS  = 3,
  parameter int unsigned LOCK_TICKS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pir_raw,
  input  logic [7:0] light_lvl,
  input  logic [7:0] temp_lvl,
  input  logic       badge_ok,
  input  logic       badge_fail,
  input  logic       logout,
  output logic       pir,
  output logic       isDark,
  output logic       tempHigh,
  output logic       authorized
);

  localparam int unsigned CNT_W   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int unsigned HOLD_W  = (PIR_HOLD > 0) ? $clog2(PIR_HOLD + 1) : 1;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned FAIL_W  = 4;

  typedef enum logic [1:0] {IDLE, AUTH, LOCKOUT} state_t;

  logic              deb, deb_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [HOLD_W-1:0] hold, hold_next;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [FAIL_W-1:0]  fail_cnt, fail_next;

  // Debounce counter and motion stretch; hold reloads from the registered deb so
  // the full stretch starts on the tick where the debounced state falls.
  always_comb begin
    deb_next  = deb;
    cnt_next  = cnt;
    hold_next = hold;
    if (tick) begin
      if (pir_raw == deb) begin
        cnt_next = '0;
      end else if (32'(cnt) + 32'd1 == DEB_TICKS) begin
        deb_next = pir_raw;
        cnt_next = '0;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
    if (deb) begin
      hold_next = HOLD_W'(PIR_HOLD);
    end else if (tick && hold != '0) begin
      hold_next = hold - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb      <= 1'b0;
      cnt      <= '0;
      hold     <= '0;
      pir      <= 1'b0;
      isDark   <= 1'b0;
      tempHigh <= 1'b0;
    end else begin
      deb  <= deb_next;
      cnt  <= cnt_next;
      hold <= hold_next;
      pir  <= deb_next | (hold_next != '0);
      if (tick) begin
        if (light_lvl < DARK_ON) begin
          isDark <= 1'b1;
        end else if (light_lvl > DARK_OFF) begin
          isDark <= 1'b0;
        end
        if (temp_lvl >= TEMP_ON) begin
          tempHigh <= 1'b1;
        end else if (temp_lvl <= TEMP_OFF) begin
          tempHigh <= 1'b0;
        end
      end
    end
  end

  // Auth FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      fail_cnt <= '0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      fail_cnt <= fail_next;
    end
  end

  // Auth FSM next state; a simultaneous ok+fail is a failure, so it never reloads.
  always_comb begin
    state_next = state;
    timer_next = timer;
    fail_next  = fail_cnt;
    case (state)
      IDLE: begin
        if (badge_fail) begin
          if (fail_cnt + FAIL_W'(1) == FAIL_W'(MAX_FAILS)) begin
            state_next = LOCKOUT;
            timer_next = TIMER_W'(LOCK_TICKS);
            fail_next  = '0;
          end else begin
            fail_next = fail_cnt + FAIL_W'(1);
          end
        end else if (badge_ok) begin
          state_next = AUTH;
          timer_next = TIMER_W'(AUTH_HOLD);
          fail_next  = '0;
        end
      end
      AUTH: begin
        if (logout) begin
          state_next = IDLE;
        end else if (badge_ok && !badge_fail) begin
          timer_next = TIMER_W'(AUTH_HOLD);
        end else if (tick) begin
          if (timer == TIMER_W'(1)) begin
            state_next = IDLE;
          end else begin
            timer_next = timer - TIMER_W'(1);
          end
        end
      end
      LOCKOUT: begin
        if (tick) begin
          if (timer == TIMER_W'(1)) begin
            state_next = IDLE;
          end else begin
            timer_next = timer - TIMER_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Auth FSM output decode
  always_comb begin
    authorized = (state == AUTH);
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed self-checking bench for sensor_conditioner: debounce/hold, hysteresis,
// badge sessions, lockout and reset override.
module tb_sensor_conditioner;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       pir_raw;
  logic [7:0] light_lvl;
  logic [7:0] temp_lvl;
  logic       badge_ok;
  logic       badge_fail;
  logic       logout;
  logic       pir;
  logic       isDark;
  logic       tempHigh;
  logic       authorized;

  int checks = 0;
  int errors = 0;

  sensor_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .pir_raw    (pir_raw),
    .light_lvl  (light_lvl),
    .temp_lvl   (temp_lvl),
    .badge_ok   (badge_ok),
    .badge_fail (badge_fail),
    .logout     (logout),
    .pir        (pir),
    .isDark     (isDark),
    .tempHigh   (tempHigh),
    .authorized (authorized)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic pulse_ok();
    badge_ok = 1'b1;
    cyc();
    badge_ok = 1'b0;
  endtask

  task automatic pulse_fail();
    badge_fail = 1'b1;
    cyc();
    badge_fail = 1'b0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with hostile inputs
    rst = 1'b1; tick = 1'b1; pir_raw = 1'b1; light_lvl = 8'd0; temp_lvl = 8'd255;
    badge_ok = 1'b1; badge_fail = 1'b0; logout = 1'b0;
    cyc();
    cyc();
    chk("rst_pir", pir, 1'b0);
    chk("rst_dark", isDark, 1'b0);
    chk("rst_temp", tempHigh, 1'b0);
    chk("rst_auth", authorized, 1'b0);
    rst = 1'b0; tick = 1'b0; pir_raw = 1'b0; light_lvl = 8'd100; temp_lvl = 8'd25;
    badge_ok = 1'b0;
    cyc();

    // Short glitch never reaches the output; a matching tick restarts the count
    pir_raw = 1'b1;
    do_tick(3);
    chk("deb_glitch3", pir, 1'b0);
    pir_raw = 1'b0;
    do_tick(1);
    pir_raw = 1'b1;
    do_tick(3);
    chk("deb_restart", pir, 1'b0);
    for (int i = 0; i < 5; i++) cyc();
    chk("deb_notick", pir, 1'b0);
    do_tick(1);
    chk("deb_rise4", pir, 1'b1);

    // Release: 4 debounce ticks + 8 hold ticks high, low on the 12th
    pir_raw = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      do_tick(1);
      chk("pir_hold", pir, 1'b1);
    end
    do_tick(1);
    chk("pir_fall12", pir, 1'b0);

    // Light hysteresis 100,70,59,70,80,81 -> 0,0,1,1,1,0
    light_lvl = 8'd100; do_tick(1); chk("dark_100", isDark, 1'b0);
    light_lvl = 8'd70;  do_tick(1); chk("dark_70a", isDark, 1'b0);
    light_lvl = 8'd59;  do_tick(1); chk("dark_59", isDark, 1'b1);
    light_lvl = 8'd70;  do_tick(1); chk("dark_70b", isDark, 1'b1);
    light_lvl = 8'd80;  do_tick(1); chk("dark_80", isDark, 1'b1);
    light_lvl = 8'd81;  do_tick(1); chk("dark_81", isDark, 1'b0);
    light_lvl = 8'd10;  cyc();      chk("dark_notick", isDark, 1'b0);
    light_lvl = 8'd100;

    // Temperature hysteresis 25,29,30,28,27 -> 0,0,1,1,0
    temp_lvl = 8'd25; do_tick(1); chk("temp_25", tempHigh, 1'b0);
    temp_lvl = 8'd29; do_tick(1); chk("temp_29", tempHigh, 1'b0);
    temp_lvl = 8'd30; do_tick(1); chk("temp_30", tempHigh, 1'b1);
    temp_lvl = 8'd28; do_tick(1); chk("temp_28", tempHigh, 1'b1);
    temp_lvl = 8'd27; do_tick(1); chk("temp_27", tempHigh, 1'b0);

    // Plain session lasts exactly 16 ticks
    pulse_ok();
    chk("auth_start", authorized, 1'b1);
    do_tick(15);
    chk("auth_t15", authorized, 1'b1);
    do_tick(1);
    chk("auth_t16", authorized, 1'b0);

    // Reload after 10 ticks extends the session to 26 ticks
    pulse_ok();
    do_tick(10);
    pulse_ok();
    do_tick(15);
    chk("reload_t25", authorized, 1'b1);
    do_tick(1);
    chk("reload_t26", authorized, 1'b0);

    // Reload on the expiring tick wins
    pulse_ok();
    do_tick(15);
    badge_ok = 1'b1; tick = 1'b1;
    cyc();
    badge_ok = 1'b0; tick = 1'b0;
    chk("reload_exp", authorized, 1'b1);
    do_tick(15);
    chk("reload_exp15", authorized, 1'b1);
    do_tick(1);
    chk("reload_exp16", authorized, 1'b0);

    // Logout mid-session, and logout while idle
    pulse_ok();
    do_tick(3);
    logout = 1'b1; cyc(); logout = 1'b0;
    chk("logout_mid", authorized, 1'b0);
    logout = 1'b1; cyc(); logout = 1'b0;
    chk("logout_idle", authorized, 1'b0);

    // ok+fail counts as failure; two more failures lock out for 32 ticks
    badge_ok = 1'b1; badge_fail = 1'b1;
    cyc();
    badge_ok = 1'b0; badge_fail = 1'b0;
    chk("okfail", authorized, 1'b0);
    pulse_fail();
    pulse_fail();
    pulse_ok();
    chk("lock_0", authorized, 1'b0);
    do_tick(20);
    pulse_ok();
    chk("lock_20", authorized, 1'b0);
    do_tick(11);
    pulse_ok();
    chk("lock_31", authorized, 1'b0);
    do_tick(1);
    pulse_ok();
    chk("lock_done", authorized, 1'b1);
    logout = 1'b1; cyc(); logout = 1'b0;
    chk("lock_logout", authorized, 1'b0);

    // Reset overrides an active session and set conditions
    light_lvl = 8'd10; do_tick(1); chk("pre_dark", isDark, 1'b1);
    temp_lvl = 8'd40;  do_tick(1); chk("pre_temp", tempHigh, 1'b1);
    pulse_ok();
    chk("pre_auth", authorized, 1'b1);
    pir_raw = 1'b1;
    do_tick(4);
    chk("pre_pir", pir, 1'b1);
    rst = 1'b1; tick = 1'b1;
    cyc();
    rst = 1'b0; tick = 1'b0;
    chk("mid_rst_pir", pir, 1'b0);
    chk("mid_rst_dark", isDark, 1'b0);
    chk("mid_rst_temp", tempHigh, 1'b0);
    chk("mid_rst_auth", authorized, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
